// File: rtl/dp_copy_engine.sv
// rtl/dp_copy_engine.sv - block-copy sequencer that borrows the datapath from the control unit; optional macro COPY_OVERLAP_EN
module dp_copy_engine #(
  parameter logic [3:0] SCRATCH_REG = 4'd15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] Src,
  input  logic [7:0] Dst,
  input  logic [7:0] Len,
  output logic       Hold_Req,
  input  logic       Hold_Ack,
  output logic       Busy,
  output logic       Done,
  input  logic       CU_D_Wr,
  input  logic       CU_RF_s,
  input  logic       CU_RF_W_en,
  input  logic [7:0] CU_D_Addr,
  input  logic [3:0] CU_RF_W_Addr,
  input  logic [3:0] CU_RF_Ra_Addr,
  input  logic [3:0] CU_RF_Rb_Addr,
  input  logic [2:0] CU_Alu_s0,
  output logic       DP_D_Wr,
  output logic       DP_RF_s,
  output logic       DP_RF_W_en,
  output logic [7:0] DP_D_Addr,
  output logic [3:0] DP_RF_W_Addr,
  output logic [3:0] DP_RF_Ra_Addr,
  output logic [3:0] DP_RF_Rb_Addr,
  output logic [2:0] DP_Alu_s0
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_LD_A = 3'd2,
    S_LD_B = 3'd3,
    S_ST   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] rd_ptr_q, rd_ptr_d;
  logic [7:0] wr_ptr_q, wr_ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] step;

`ifdef COPY_OVERLAP_EN
  // A forward move into an overlapping window must copy from the top down
  // so that source words are read before they are overwritten.
  logic desc_q, desc_d;
  logic overlap;
  assign overlap = (Len != 8'd0) && (Dst > Src) && ((Dst - Src) < Len);
  assign step    = desc_q ? 8'hFF : 8'h01;
`else
  assign step    = 8'h01;
`endif

  // State and operand registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= 8'd0;
      wr_ptr_q <= 8'd0;
      cnt_q    <= 8'd0;
`ifdef COPY_OVERLAP_EN
      desc_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
`ifdef COPY_OVERLAP_EN
      desc_q   <= desc_d;
`endif
    end
  end

  // Next-state logic and datapath bus multiplexing
  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    cnt_d         = cnt_q;
`ifdef COPY_OVERLAP_EN
    desc_d        = desc_q;
`endif
    Busy          = (state_q != S_IDLE);
    Hold_Req      = 1'b0;
    Done          = 1'b0;
    DP_D_Wr       = CU_D_Wr;
    DP_RF_s       = CU_RF_s;
    DP_RF_W_en    = CU_RF_W_en;
    DP_D_Addr     = CU_D_Addr;
    DP_RF_W_Addr  = CU_RF_W_Addr;
    DP_RF_Ra_Addr = CU_RF_Ra_Addr;
    DP_RF_Rb_Addr = CU_RF_Rb_Addr;
    DP_Alu_s0     = CU_Alu_s0;

    // While the engine owns the datapath, every unlisted control field is 0.
    if (state_q == S_LD_A || state_q == S_LD_B || state_q == S_ST) begin
      Hold_Req      = 1'b1;
      DP_D_Wr       = 1'b0;
      DP_RF_s       = 1'b0;
      DP_RF_W_en    = 1'b0;
      DP_D_Addr     = 8'd0;
      DP_RF_W_Addr  = 4'd0;
      DP_RF_Ra_Addr = 4'd0;
      DP_RF_Rb_Addr = 4'd0;
      DP_Alu_s0     = 3'd0;
    end

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          rd_ptr_d = Src;
          wr_ptr_d = Dst;
          cnt_d    = Len;
`ifdef COPY_OVERLAP_EN
          desc_d   = overlap;
          if (overlap) begin
            rd_ptr_d = Src + Len - 8'd1;
            wr_ptr_d = Dst + Len - 8'd1;
          end
`endif
          state_d  = (Len == 8'd0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        Hold_Req = 1'b1;
        if (Hold_Ack) state_d = S_LD_A;
      end
      S_LD_A: begin
        DP_D_Addr = rd_ptr_q;
        DP_RF_s   = 1'b1;
        state_d   = S_LD_B;
      end
      S_LD_B: begin
        DP_D_Addr    = rd_ptr_q;
        DP_RF_s      = 1'b1;
        DP_RF_W_en   = 1'b1;
        DP_RF_W_Addr = SCRATCH_REG;
        state_d      = S_ST;
      end
      S_ST: begin
        DP_D_Addr     = wr_ptr_q;
        DP_D_Wr       = 1'b1;
        DP_RF_Ra_Addr = SCRATCH_REG;
        cnt_d         = cnt_q - 8'd1;
        rd_ptr_d      = rd_ptr_q + step;
        wr_ptr_d      = wr_ptr_q + step;
        state_d       = (cnt_q == 8'd1) ? S_DONE : S_LD_A;
      end
      S_DONE: begin
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dp_copy_engine.sv
// tb/tb_dp_copy_engine.sv - self-checking bench for dp_copy_engine with a datapath memory/register-file model
module tb_dp_copy_engine;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1, Start = 1'b0, Hold_Ack = 1'b1;
  logic [7:0] Src = 8'd0, Dst = 8'd0, Len = 8'd0;
  logic       Hold_Req, Busy, Done;
  logic       CU_D_Wr = 1'b0, CU_RF_s = 1'b0, CU_RF_W_en = 1'b0;
  logic [7:0] CU_D_Addr = 8'd0;
  logic [3:0] CU_RF_W_Addr = 4'd0, CU_RF_Ra_Addr = 4'd0, CU_RF_Rb_Addr = 4'd0;
  logic [2:0] CU_Alu_s0 = 3'd0;
  logic       DP_D_Wr, DP_RF_s, DP_RF_W_en;
  logic [7:0] DP_D_Addr;
  logic [3:0] DP_RF_W_Addr, DP_RF_Ra_Addr, DP_RF_Rb_Addr;
  logic [2:0] DP_Alu_s0;

  always #5 Clk = ~Clk;

  dp_copy_engine #(.SCRATCH_REG(4'd15)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Src(Src), .Dst(Dst), .Len(Len),
    .Hold_Req(Hold_Req), .Hold_Ack(Hold_Ack), .Busy(Busy), .Done(Done),
    .CU_D_Wr(CU_D_Wr), .CU_RF_s(CU_RF_s), .CU_RF_W_en(CU_RF_W_en),
    .CU_D_Addr(CU_D_Addr), .CU_RF_W_Addr(CU_RF_W_Addr),
    .CU_RF_Ra_Addr(CU_RF_Ra_Addr), .CU_RF_Rb_Addr(CU_RF_Rb_Addr), .CU_Alu_s0(CU_Alu_s0),
    .DP_D_Wr(DP_D_Wr), .DP_RF_s(DP_RF_s), .DP_RF_W_en(DP_RF_W_en),
    .DP_D_Addr(DP_D_Addr), .DP_RF_W_Addr(DP_RF_W_Addr),
    .DP_RF_Ra_Addr(DP_RF_Ra_Addr), .DP_RF_Rb_Addr(DP_RF_Rb_Addr), .DP_Alu_s0(DP_Alu_s0)
  );

  int n_checks = 0, n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // Datapath model: synchronous-read memory and register file
  logic [15:0] mem [256];
  logic [15:0] img [256];
  logic [15:0] exp_mem [256];
  logic [15:0] rf [16];
  logic [15:0] mem_rd_q;
  bit          load_req = 1'b0;

  always @(posedge Clk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (DP_D_Wr) begin
      mem[DP_D_Addr] <= rf[DP_RF_Ra_Addr];
    end
    mem_rd_q <= mem[DP_D_Addr];
    if (DP_RF_W_en) rf[DP_RF_W_Addr] <= DP_RF_s ? mem_rd_q : 16'h0000;
  end

  // Control unit drives arbitrary values on its bus (never a memory write)
  initial forever begin
    @(negedge Clk);
    CU_RF_s       = 1'($urandom);
    CU_RF_W_en    = 1'($urandom);
    CU_D_Addr     = 8'($urandom);
    CU_RF_W_Addr  = 4'($urandom_range(0, 14));
    CU_RF_Ra_Addr = 4'($urandom);
    CU_RF_Rb_Addr = 4'($urandom);
    CU_Alu_s0     = 3'($urandom);
  end

  function automatic bit desc_rule(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
`ifdef COPY_OVERLAP_EN
    return (l != 8'd0) && (d > s) && (8'(d - s) < l);
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: copy windows in cycle-index terms
  int         cyc = 0;
  bit         m_active = 1'b0, m_granted = 1'b0, m_desc = 1'b0;
  logic [7:0] m_src, m_dst;
  int         m_n = 0, m_tg = 0;

  always @(posedge Clk) begin
    cyc = cyc + 1;
    if (Reset) m_active = 1'b0;
    else if (m_active) begin
      if (m_granted && cyc == m_tg + 3 * m_n + 1) m_active = 1'b0;
      else if (!m_granted && Hold_Ack) begin
        m_granted = 1'b1;
        m_tg = cyc;
      end
    end else if (Start) begin
      m_active  = 1'b1;
      m_src     = Src;
      m_dst     = Dst;
      m_n       = int'(Len);
      m_granted = (Len == 8'd0);
      m_tg      = cyc;
      m_desc    = desc_rule(Src, Dst, Len);
    end
  end

  int busy_cnt = 0, hold_cnt = 0, done_cnt = 0, done_cyc = -1;

  // Per-cycle comparison of all outputs against the model
  initial begin
    logic [28:0] exp_v, act_v;
    logic        eb, eh, ed, dwr, rfs, wen;
    logic [7:0]  addr, rp, wp;
    logic [3:0]  wa, ra, rb;
    logic [2:0]  alu;
    int          off, w;
    forever begin
      @(negedge Clk);
      #1;
      if (chk_en) begin
        {dwr, rfs, wen, addr, wa, ra, rb, alu} =
          {CU_D_Wr, CU_RF_s, CU_RF_W_en, CU_D_Addr, CU_RF_W_Addr, CU_RF_Ra_Addr, CU_RF_Rb_Addr, CU_Alu_s0};
        eb = 1'b0; eh = 1'b0; ed = 1'b0;
        if (m_active) begin
          eb = 1'b1;
          if (!m_granted) eh = 1'b1;
          else begin
            off = cyc - m_tg;
            if (off == 3 * m_n) ed = 1'b1;
            else begin
              eh = 1'b1;
              w  = off / 3;
              rp = m_desc ? 8'(int'(m_src) + m_n - 1 - w) : 8'(int'(m_src) + w);
              wp = m_desc ? 8'(int'(m_dst) + m_n - 1 - w) : 8'(int'(m_dst) + w);
              {dwr, rfs, wen, addr, wa, ra, rb, alu} = '0;
              case (off % 3)
                0:       begin addr = rp; rfs = 1'b1; end
                1:       begin addr = rp; rfs = 1'b1; wen = 1'b1; wa = 4'd15; end
                default: begin addr = wp; dwr = 1'b1; ra = 4'd15; end
              endcase
            end
          end
        end
        exp_v = {eb, eh, ed, dwr, rfs, wen, addr, wa, ra, rb, alu};
        act_v = {Busy, Hold_Req, Done, DP_D_Wr, DP_RF_s, DP_RF_W_en, DP_D_Addr,
                 DP_RF_W_Addr, DP_RF_Ra_Addr, DP_RF_Rb_Addr, DP_Alu_s0};
        chk($sformatf("outputs@%0d", cyc), 32'(act_v), 32'(exp_v));
        if (Busy) busy_cnt++;
        if (Hold_Req) hold_cnt++;
        if (Done) begin done_cnt++; done_cyc = cyc; end
      end
    end
  end

  int start_edge = 0;

  task automatic default_img();
    for (int i = 0; i < 256; i++) img[i] = 16'h5A00 | 16'(i);
  endtask

  task automatic load_image();
    load_req = 1'b1;
    Reset = 1'b1;
    @(negedge Clk);
    load_req = 1'b0;
    Reset = 1'b0;
    for (int i = 0; i < 256; i++) exp_mem[i] = img[i];
    busy_cnt = 0; hold_cnt = 0; done_cnt = 0; done_cyc = -1;
  endtask

  task automatic start_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    Src = s; Dst = d; Len = l; Start = 1'b1;
    start_edge = cyc + 1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int i = 0;
    #2;
    while (Busy && i < 100) begin
      @(negedge Clk);
      #2;
      i++;
    end
    chk({nm, "_timeout"}, 32'(Busy), 32'd0);
    repeat (2) @(negedge Clk);
  endtask

  task automatic apply_copy(input logic [7:0] s, input logic [7:0] d, input int n, input bit desc);
    if (desc) for (int w = n - 1; w >= 0; w--) exp_mem[8'(int'(d) + w)] = exp_mem[8'(int'(s) + w)];
    else      for (int w = 0; w < n; w++)      exp_mem[8'(int'(d) + w)] = exp_mem[8'(int'(s) + w)];
  endtask

  task automatic check_mem(input string nm);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk({nm, "_mem_words_wrong"}, 32'(bad), 32'd0);
  endtask

  initial begin
    default_img();
    repeat (2) @(negedge Clk);
    #2;
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_hold", 32'(Hold_Req), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_passthru", 32'(DP_D_Addr), 32'(CU_D_Addr));
    chk_en = 1'b1;

    // Basic copy
    default_img();
    img[8'h10] = 16'hAAAA; img[8'h11] = 16'hBBBB; img[8'h12] = 16'hCCCC;
    load_image();
    start_copy(8'h10, 8'h40, 8'd3);
    wait_idle("basic");
    apply_copy(8'h10, 8'h40, 3, 1'b0);
    check_mem("basic");
    chk("basic_w0", 32'(mem[8'h40]), 32'h0000AAAA);
    chk("basic_w1", 32'(mem[8'h41]), 32'h0000BBBB);
    chk("basic_w2", 32'(mem[8'h42]), 32'h0000CCCC);
    chk("basic_busy_cycles", 32'(busy_cnt), 32'd11);
    chk("basic_hold_cycles", 32'(hold_cnt), 32'd10);
    chk("basic_done_width", 32'(done_cnt), 32'd1);
    chk("basic_done_latency", 32'(done_cyc - start_edge), 32'd10);

    // Empty copy
    default_img();
    load_image();
    start_copy(8'h10, 8'h40, 8'd0);
    wait_idle("empty");
    check_mem("empty");
    chk("empty_done_latency", 32'(done_cyc - start_edge), 32'd0);
    chk("empty_hold_cycles", 32'(hold_cnt), 32'd0);
    chk("empty_busy_cycles", 32'(busy_cnt), 32'd1);

    // Wrap-around
    default_img();
    img[8'hFE] = 16'h1111; img[8'hFF] = 16'h2222; img[8'h00] = 16'h3333; img[8'h01] = 16'h4444;
    load_image();
    start_copy(8'hFE, 8'h20, 8'd4);
    wait_idle("wrap");
    apply_copy(8'hFE, 8'h20, 4, 1'b0);
    check_mem("wrap");
    chk("wrap_w0", 32'(mem[8'h20]), 32'h00001111);
    chk("wrap_w3", 32'(mem[8'h23]), 32'h00004444);

    // Grant stall with an ignored second Start
    default_img();
    load_image();
    Hold_Ack = 1'b0;
    start_copy(8'h50, 8'h60, 8'd2);
    start_copy(8'h70, 8'h80, 8'd5);
    repeat (3) @(negedge Clk);
    #2;
    chk("stall_no_wr", 32'(DP_D_Wr), 32'd0);
    chk("stall_hold", 32'(Hold_Req), 32'd1);
    Hold_Ack = 1'b1;
    wait_idle("stall");
    apply_copy(8'h50, 8'h60, 2, 1'b0);
    check_mem("stall");
    chk("stall_w0", 32'(mem[8'h60]), 32'h00005A50);
    chk("stall_ignored", 32'(mem[8'h80]), 32'h00005A80);

    // Reset during the second store
    default_img();
    img[8'h90] = 16'h0005; img[8'h91] = 16'h0006; img[8'h92] = 16'h0007; img[8'h93] = 16'h0008;
    load_image();
    start_copy(8'h90, 8'hA0, 8'd4);
    repeat (6) @(negedge Clk);
    #2;
    chk("rst_second_st_wr", 32'(DP_D_Wr), 32'd1);
    chk("rst_second_st_addr", 32'(DP_D_Addr), 32'h000000A1);
    Reset = 1'b1;
    @(negedge Clk);
    #2;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_hold", 32'(Hold_Req), 32'd0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    apply_copy(8'h90, 8'hA0, 2, 1'b0);
    check_mem("rst");
    chk("rst_w0", 32'(mem[8'hA0]), 32'h00000005);
    chk("rst_w2_untouched", 32'(mem[8'hA2]), 32'h00005AA2);

    // Overlapping forward move
    default_img();
    img[8'h30] = 16'd1; img[8'h31] = 16'd2; img[8'h32] = 16'd3; img[8'h33] = 16'd4;
    load_image();
    start_copy(8'h30, 8'h31, 8'd4);
    wait_idle("overlap");
    apply_copy(8'h30, 8'h31, 4, desc_rule(8'h30, 8'h31, 8'd4));
    check_mem("overlap");
    chk("overlap_busy_cycles", 32'(busy_cnt), 32'd14);
`ifdef COPY_OVERLAP_EN
    chk("overlap_w0", 32'(mem[8'h31]), 32'd1);
    chk("overlap_w1", 32'(mem[8'h32]), 32'd2);
    chk("overlap_w3", 32'(mem[8'h34]), 32'd4);
`else
    chk("overlap_w0", 32'(mem[8'h31]), 32'd1);
    chk("overlap_w1", 32'(mem[8'h32]), 32'd1);
    chk("overlap_w3", 32'(mem[8'h34]), 32'd1);
`endif

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
